// File: rtl/debug_pd_capture_sequencer.sv
// Debug PD capture sequencer: arms the PD capture block, waits for a match
// (or timeout), then reads the frozen PD out word by word through the
// multicycle word mux and streams each word downstream with a handshake.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for cfg_start; capture block disarmed
// WAIT_MATCH | capture armed; waiting for capture_match_i or timeout
// SETTLE     | one cycle for the PD register stage after the capture
// READ       | word select applied; waiting out the mux latency, then sample
// PUSH       | out_valid held with stable data until out_ready
// DONE       | one-cycle done pulse, then back to IDLE
module debug_pd_capture_sequencer #(
  parameter int PD_WIDTH      = 100,
  parameter int MUX_LATENCY   = 2,
  parameter int TIMEOUT_WIDTH = 16,
  localparam int NUM_WORDS    = (PD_WIDTH + 31) / 32,
  localparam int SEL_W        = $clog2(NUM_WORDS)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cfg_start,
  input  logic                     cfg_abort,
  input  logic                     cfg_cnt_en,
  input  logic                     cfg_trigger_en,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  input  logic                     capture_match_i,
  input  logic [31:0]              pd_word_i,
  input  logic                     out_ready,
  output logic [3:0]               debug_pd_en_reg,
  output logic [SEL_W:0]           captured_word_sel,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_o
);

  // Latency counter counts cycles since the last select change; it must
  // reach MUX_LATENCY, so it needs to hold 0..MUX_LATENCY.
  localparam int LAT_W = (MUX_LATENCY > 0) ? $clog2(MUX_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_DONE = LAT_W'(MUX_LATENCY);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_MATCH = 3'd1,
    SETTLE     = 3'd2,
    READ       = 3'd3,
    PUSH       = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic [SEL_W-1:0]         idx_q, idx_d;
  logic [3:0]               en_reg_q, en_reg_d;
  logic                     out_valid_q, out_valid_d;
  logic [31:0]              out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;
  logic [SEL_W-1:0]         out_idx_q, out_idx_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     timeout_q, timeout_d;

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    lat_d      = lat_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_idx_d  = out_idx_q;
    timeout_d  = timeout_q;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d   = WAIT_MATCH;
          to_cnt_d  = '0;
          timeout_d = 1'b0;
        end
      end
      WAIT_MATCH: begin
        to_cnt_d = to_cnt_q + TIMEOUT_WIDTH'(1);
        // A match in the timeout cycle wins.
        if (capture_match_i) begin
          state_d = SETTLE;
          idx_d   = '0;
          lat_d   = '0;
        end else if ((cfg_timeout != '0) &&
                     (to_cnt_q == (cfg_timeout - TIMEOUT_WIDTH'(1)))) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      SETTLE: begin
        lat_d   = lat_q + LAT_W'(1);
        state_d = READ;
      end
      READ: begin
        if (lat_q >= LAT_DONE) begin
          out_data_d = pd_word_i;
          out_idx_d  = idx_q;
          out_last_d = (idx_q == LAST_IDX);
          state_d    = PUSH;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      PUSH: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            if (idx_q != LAST_IDX) begin
              idx_d = idx_q + SEL_W'(1);
            end
            lat_d   = '0;
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything and leaves the timeout flag untouched.
    if (cfg_abort) begin
      state_d   = IDLE;
      timeout_d = timeout_q;
    end

    if (state_d == IDLE) begin
      idx_d = '0;
    end

    // Capture block is only armed while waiting for a match.
    if (state_d == WAIT_MATCH) begin
      en_reg_d = {1'b0, cfg_trigger_en, 1'b1, cfg_cnt_en};
    end else begin
      en_reg_d = {1'b0, 1'b0, 1'b0, cfg_cnt_en};
    end

    out_valid_d = (state_d == PUSH);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      lat_q       <= '0;
      idx_q       <= '0;
      en_reg_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      lat_q       <= lat_d;
      idx_q       <= idx_d;
      en_reg_q    <= en_reg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign debug_pd_en_reg   = en_reg_q;
  assign captured_word_sel = {idx_q, 1'b0};
  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_last          = out_last_q;
  assign out_idx           = out_idx_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_debug_pd_capture_sequencer.sv
// Directed bench for debug_pd_capture_sequencer with default parameters
// (4 words, mux latency 2). The word mux is modelled as a two-stage delay
// of captured_word_sel selecting from a fixed PD image.
module tb_debug_pd_capture_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_start;
  logic        cfg_abort;
  logic        cfg_cnt_en;
  logic        cfg_trigger_en;
  logic [15:0] cfg_timeout;
  logic        capture_match_i;
  logic [31:0] pd_word_i;
  logic        out_ready;
  logic [3:0]  debug_pd_en_reg;
  logic [2:0]  captured_word_sel;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic [1:0]  out_idx;
  logic        busy;
  logic        done;
  logic        timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Top word is partial (4 of 32 bits used) but must pass through as-is.
  logic [31:0] words [4] = '{32'h1111_A0A0, 32'h2222_B1B1, 32'h3333_C2C2, 32'hDEAD_BEE3};
  logic [2:0]  sel_p1, sel_p2;

  always #5 clk = ~clk;

  // Two-cycle word mux model.
  always @(posedge clk) begin
    sel_p1 <= captured_word_sel;
    sel_p2 <= sel_p1;
  end
  assign pd_word_i = words[sel_p2[2:1]];

  debug_pd_capture_sequencer dut (
    .clk               (clk),
    .rstn              (rstn),
    .cfg_start         (cfg_start),
    .cfg_abort         (cfg_abort),
    .cfg_cnt_en        (cfg_cnt_en),
    .cfg_trigger_en    (cfg_trigger_en),
    .cfg_timeout       (cfg_timeout),
    .capture_match_i   (capture_match_i),
    .pd_word_i         (pd_word_i),
    .out_ready         (out_ready),
    .debug_pd_en_reg   (debug_pd_en_reg),
    .captured_word_sel (captured_word_sel),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_last          (out_last),
    .out_idx           (out_idx),
    .busy              (busy),
    .done              (done),
    .timeout_o         (timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout_o), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_idx"}, 32'(out_idx), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_en"}, 32'(debug_pd_en_reg), 32'd0);
    chk({tag, "_sel"}, 32'(captured_word_sel), 32'd0);
  endtask

  // Start a capture and deliver a one-cycle match on cycle match_cyc of WAIT_MATCH.
  task automatic start_and_match(input int match_cyc);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_en", 32'(debug_pd_en_reg), 32'b0111);
    repeat (match_cyc - 1) step();
    capture_match_i = 1'b1;
    step();
    capture_match_i = 1'b0;
    chk("match_en", 32'(debug_pd_en_reg), 32'b0001);
  endtask

  // Collect beats after a match; optional stall and abort on a given beat.
  task automatic readout(input int stall_beat, input int abort_beat,
                         output int beats, output int dones);
    beats = 0;
    dones = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      step();
      if (done) dones++;
      if (out_valid) begin
        if (beats == 0) chk("first_lat", 32'(cyc), 32'd2);
        chk("beat_data", out_data, words[beats]);
        chk("beat_idx", 32'(out_idx), 32'(beats));
        chk("beat_last", 32'(out_last), 32'(beats == 3));
        chk("beat_sel", 32'(captured_word_sel), 32'(beats * 2));
        if (beats == stall_beat) begin
          out_ready = 1'b0;
          for (int s = 0; s < 7; s++) begin
            cfg_start = (s == 3);
            step();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", out_data, words[beats]);
            chk("stall_sel", 32'(captured_word_sel), 32'(beats * 2));
          end
          cfg_start = 1'b0;
          out_ready = 1'b1;
        end
        if (beats == abort_beat) begin
          out_ready = 1'b0;
          cfg_abort = 1'b1;
          step();
          cfg_abort = 1'b0;
          chk("abort_valid", 32'(out_valid), 32'd0);
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_trig_en", 32'(debug_pd_en_reg[1]), 32'd0);
          chk("abort_sel", 32'(captured_word_sel), 32'd0);
          if (done) dones++;
          for (int s = 0; s < 6; s++) begin
            step();
            if (done) dones++;
          end
          out_ready = 1'b1;
          beats++;
          break;
        end
        beats++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int beats, dones, n;
    logic saw_valid;

    rstn            = 1'b0;
    cfg_start       = 1'b0;
    cfg_abort       = 1'b0;
    cfg_cnt_en      = 1'b1;
    cfg_trigger_en  = 1'b1;
    cfg_timeout     = 16'd0;
    capture_match_i = 1'b0;
    out_ready       = 1'b1;
    repeat (3) step();
    check_all_zero("rst");
    rstn = 1'b1;
    step();
    chk("idle_en", 32'(debug_pd_en_reg), 32'b0001);

    // Basic readout
    start_and_match(5);
    readout(-1, -1, beats, dones);
    chk("basic_beats", 32'(beats), 32'd4);
    chk("basic_done", 32'(dones), 32'd1);
    chk("basic_idle", 32'(busy), 32'd0);

    // Timeout with no match
    cfg_timeout = 16'd10;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("to_clr", 32'(timeout_o), 32'd0);
    n = 0;
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      n++;
      if (out_valid) saw_valid = 1'b1;
      if (done) break;
    end
    chk("to_cycles", 32'(n), 32'd10);
    chk("to_flag", 32'(timeout_o), 32'd1);
    chk("to_novalid", 32'(saw_valid), 32'd0);
    step();
    chk("to_done_once", 32'(done), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_hold", 32'(timeout_o), 32'd1);

    // Match in the timeout cycle wins
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("mt_clr", 32'(timeout_o), 32'd0);
    repeat (9) step();
    capture_match_i = 1'b1;
    step();
    capture_match_i = 1'b0;
    chk("mt_tmo", 32'(timeout_o), 32'd0);
    chk("mt_busy", 32'(busy), 32'd1);
    chk("mt_en", 32'(debug_pd_en_reg), 32'b0001);
    readout(-1, -1, beats, dones);
    chk("mt_beats", 32'(beats), 32'd4);
    chk("mt_done", 32'(dones), 32'd1);
    chk("mt_tmo_end", 32'(timeout_o), 32'd0);
    cfg_timeout = 16'd0;

    // Backpressure on beat 1 (a stray cfg_start mid-stall must be ignored)
    start_and_match(3);
    readout(1, -1, beats, dones);
    chk("bp_beats", 32'(beats), 32'd4);
    chk("bp_done", 32'(dones), 32'd1);

    // Abort during beat 2
    start_and_match(4);
    readout(-1, 2, beats, dones);
    chk("ab_beats", 32'(beats), 32'd3);
    chk("ab_done", 32'(dones), 32'd0);
    chk("ab_tmo", 32'(timeout_o), 32'd0);

    // Reset during READ, then a normal capture
    start_and_match(2);
    step();
    step();
    rstn = 1'b0;
    step();
    check_all_zero("rr");
    rstn = 1'b1;
    step();
    start_and_match(5);
    readout(-1, -1, beats, dones);
    chk("rr_beats", 32'(beats), 32'd4);
    chk("rr_done", 32'(dones), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
